jtag_debug_host_shifter: RTL and testbench



---
 rtl/jtag_debug_host_shifter.sv | 148 ++++++++++++++
 tb/tb_jtag_debug_host_shifter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_debug_host_shifter.sv
// rtl/jtag_debug_host_shifter.sv - virtual-JTAG debug host: one IR load plus one DR shift per command
// Optional RTI hold after update-DR: define JTAG_HOST_RTI_HOLD_EN.
module jtag_debug_host_shifter #(
   parameter int TCK_DIV    = 2,
   parameter int DR_W       = 38,
   parameter int RTI_CYCLES = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [1:0]      cmd_ir,
   input  logic [DR_W-1:0] cmd_data,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [DR_W-1:0] resp_data,
   output logic            tck,
   output logic            tdi,
   input  logic            tdo,
   output logic [1:0]      ir_in,
   output logic            vs_uir,
   output logic            vs_cdr,
   output logic            vs_sdr,
   output logic            vs_udr,
   output logic            jtag_state_rti
);

   localparam int DW = ($clog2(2*TCK_DIV) < 1) ? 1 : $clog2(2*TCK_DIV);
   localparam int BW = (DR_W > 1) ? $clog2(DR_W) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(2*TCK_DIV-1);
   localparam logic [DW-1:0] DIV_PRE  = DW'(TCK_DIV-1);
   localparam logic [DW-1:0] DIV_HIGH = DW'(TCK_DIV);
   localparam logic [BW-1:0] BIT_LAST = BW'(DR_W-1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      UIR  = 3'd1,
      CDR  = 3'd2,
      SDR  = 3'd3,
      UDR  = 3'd4,
`ifdef JTAG_HOST_RTI_HOLD_EN
      RTI  = 3'd5,
`endif
      DONE = 3'd6
   } state_t;

   state_t          state, next_state;
   logic [DW-1:0]   div, next_div;
   logic [BW-1:0]   bit_cnt;
   logic [DR_W-1:0] data_q;
   logic            active, next_active, period_end;

   assign active      = (state != IDLE) && (state != DONE);
   assign next_active = (next_state != IDLE) && (next_state != DONE);
   assign period_end  = active && (div == DIV_LAST);
   assign next_div    = (active && !period_end) ? div + 1'b1 : '0;

`ifdef JTAG_HOST_RTI_HOLD_EN
   localparam int RW = ($clog2(RTI_CYCLES+1) < 1) ? 1 : $clog2(RTI_CYCLES+1);
   localparam logic [RW-1:0] RTI_LAST = RW'(RTI_CYCLES-1);
   logic [RW-1:0] rti_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         rti_cnt <= '0;
      else if (state != RTI)
         rti_cnt <= '0;
      else if (period_end)
         rti_cnt <= rti_cnt + 1'b1;
   end
`else
   assign jtag_state_rti = 1'b0 & (RTI_CYCLES != 0);
`endif

   // tck is registered from the next-cycle divider so the pin never glitches
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         div       <= '0;
         tck       <= 1'b0;
         bit_cnt   <= '0;
         data_q    <= '0;
         ir_in     <= 2'b00;
         resp_data <= '0;
      end else begin
         state <= next_state;
         div   <= next_div;
         tck   <= next_active && (next_div >= DIV_HIGH);
         if (state == IDLE && cmd_valid) begin
            data_q    <= cmd_data;
            ir_in     <= cmd_ir;
            bit_cnt   <= '0;
            resp_data <= '0;
         end
         if (state == SDR && div == DIV_PRE)
            resp_data[bit_cnt] <= tdo;
         if (state == SDR && period_end && bit_cnt != BIT_LAST)
            bit_cnt <= bit_cnt + 1'b1;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (cmd_valid) next_state = UIR;
         UIR:  if (period_end) next_state = CDR;
         CDR:  if (period_end) next_state = SDR;
         SDR:  if (period_end && bit_cnt == BIT_LAST) next_state = UDR;
`ifdef JTAG_HOST_RTI_HOLD_EN
         UDR:  if (period_end) next_state = RTI;
         RTI:  if (period_end && rti_cnt == RTI_LAST) next_state = DONE;
`else
         UDR:  if (period_end) next_state = DONE;
`endif
         DONE: if (resp_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready  = 1'b0;
      resp_valid = 1'b0;
      vs_uir     = 1'b0;
      vs_cdr     = 1'b0;
      vs_sdr     = 1'b0;
      vs_udr     = 1'b0;
      tdi        = 1'b0;
`ifdef JTAG_HOST_RTI_HOLD_EN
      jtag_state_rti = 1'b0;
`endif
      case (state)
         IDLE: cmd_ready = 1'b1;
         UIR:  vs_uir = 1'b1;
         CDR:  vs_cdr = 1'b1;
         SDR: begin
            vs_sdr = 1'b1;
            tdi    = data_q[bit_cnt];
         end
         UDR:  vs_udr = 1'b1;
`ifdef JTAG_HOST_RTI_HOLD_EN
         RTI:  jtag_state_rti = 1'b1;
`endif
         DONE: resp_valid = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_jtag_debug_host_shifter.sv
// tb/tb_jtag_debug_host_shifter.sv - scoreboard bench for jtag_debug_host_shifter
module tb_jtag_debug_host_shifter;
   localparam int DR_W = 38;
`ifdef JTAG_HOST_RTI_HOLD_EN
   localparam int RTI_P = 4;
`else
   localparam int RTI_P = 0;
`endif
   localparam int LAT_A = (DR_W + 3 + RTI_P) * 2 * 2 + 1;
   localparam int LAT_B = (DR_W + 3 + RTI_P) * 2 * 1 + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   logic a_cmd_valid = 0, a_cmd_ready, a_resp_valid, a_resp_ready = 0;
   logic [1:0] a_cmd_ir = 0, a_ir_in;
   logic [DR_W-1:0] a_cmd_data = 0, a_resp_data;
   logic a_tck, a_tdi, a_tdo, a_uir, a_cdr, a_sdr, a_udr, a_rti;
   int tdo_mode = 0;
   assign a_tdo = (tdo_mode == 0) ? a_tdi : (tdo_mode == 1) ? ~a_tdi : (tdo_mode == 2);

   logic b_cmd_valid = 0, b_cmd_ready, b_resp_valid, b_resp_ready = 1;
   logic [1:0] b_cmd_ir = 0, b_ir_in;
   logic [DR_W-1:0] b_cmd_data = 0, b_resp_data;
   logic b_tck, b_tdi, b_uir, b_cdr, b_sdr, b_udr, b_rti;

   jtag_debug_host_shifter #(.TCK_DIV(2), .DR_W(DR_W), .RTI_CYCLES(4)) u_a (
      .clk(clk), .reset(rst), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
      .cmd_ir(a_cmd_ir), .cmd_data(a_cmd_data), .resp_valid(a_resp_valid),
      .resp_ready(a_resp_ready), .resp_data(a_resp_data), .tck(a_tck), .tdi(a_tdi),
      .tdo(a_tdo), .ir_in(a_ir_in), .vs_uir(a_uir), .vs_cdr(a_cdr), .vs_sdr(a_sdr),
      .vs_udr(a_udr), .jtag_state_rti(a_rti));

   jtag_debug_host_shifter #(.TCK_DIV(1), .DR_W(DR_W), .RTI_CYCLES(4)) u_b (
      .clk(clk), .reset(rst), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
      .cmd_ir(b_cmd_ir), .cmd_data(b_cmd_data), .resp_valid(b_resp_valid),
      .resp_ready(b_resp_ready), .resp_data(b_resp_data), .tck(b_tck), .tdi(b_tdi),
      .tdo(b_tdi), .ir_in(b_ir_in), .vs_uir(b_uir), .vs_cdr(b_cdr), .vs_sdr(b_sdr),
      .vs_udr(b_udr), .jtag_state_rti(b_rti));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [DR_W-1:0] model(input logic [DR_W-1:0] d, input int mode);
      case (mode)
         0:       return d;
         1:       return ~d;
         2:       return '1;
         default: return '0;
      endcase
   endfunction

   typedef struct {
      logic [DR_W-1:0] data;
      logic [1:0]      ir;
      int              acc;
      int              hold;
      int              ones;
   } exp_t;
   exp_t sb[$];

   // monitor-side activity counters for DUT a
   int sdr_n = 0, tdi_in = 0, tdi_out = 0, strobe_bad = 0;

   task automatic tick();
      int sum;
      @(negedge clk);
      if (rst) begin
         sdr_n = 0; tdi_in = 0; tdi_out = 0; strobe_bad = 0;
      end else begin
         sum = int'(a_uir) + int'(a_cdr) + int'(a_sdr) + int'(a_udr) + int'(a_rti);
         if (a_cmd_ready || a_resp_valid) begin
            if (sum != 0 || a_tck) strobe_bad++;
         end else if (sum != 1) strobe_bad++;
         if (a_sdr) begin
            sdr_n++;
            if (a_tdi) tdi_in++;
         end else if (a_tdi) tdi_out++;
      end
   endtask

   initial begin : monitor
      exp_t e;
      logic stable;
      forever begin
         tick();
         if (!rst && a_resp_valid) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_resp actual=%0h required=none", a_resp_data);
            end else begin
               e = sb.pop_front();
               check("latency", 64'(cyc - e.acc), 64'(LAT_A));
               check("resp_data", 64'(a_resp_data), 64'(e.data));
               check("ir_in", 64'(a_ir_in), 64'(e.ir));
               check("sdr_cycles", 64'(sdr_n), 64'(DR_W * 4));
               check("tdi_ones_sdr", 64'(tdi_in), 64'(e.ones));
               check("tdi_outside_sdr", 64'(tdi_out), 64'd0);
               check("strobe_onehot", 64'(strobe_bad), 64'd0);
               stable = 1'b1;
               for (int i = 0; i < e.hold; i++) begin
                  tick();
                  if (!a_resp_valid || a_resp_data !== e.data || a_cmd_ready) stable = 1'b0;
               end
               if (e.hold > 0) check("done_hold_stable", 64'(stable), 64'd1);
               a_resp_ready = 1'b1;
               check("cmd_ready_in_done", 64'(a_cmd_ready), 64'd0);
               tick();
               a_resp_ready = 1'b0;
               check("resp_valid_drop", 64'(a_resp_valid), 64'd0);
               check("cmd_ready_back", 64'(a_cmd_ready), 64'd1);
               sdr_n = 0; tdi_in = 0; tdi_out = 0; strobe_bad = 0;
            end
         end
      end
   end

   task automatic push_exp(input logic [DR_W-1:0] d, input logic [1:0] ir, input int acc, input int hold);
      exp_t e;
      e.data = model(d, tdo_mode);
      e.ir   = ir;
      e.acc  = acc;
      e.hold = hold;
      e.ones = $countones(d) * 4;
      sb.push_back(e);
   endtask

   task automatic wait_ready(input string name, output int acc);
      int t = 0;
      while (!a_cmd_ready && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 1000) begin
         checks++; errors++;
         $display("FAIL %s_timeout actual=busy required=cmd_ready", name);
      end
      acc = cyc;
   endtask

   task automatic send(input logic [1:0] ir, input logic [DR_W-1:0] d, input int hold, input bit push, output int acc);
      @(negedge clk);
      a_cmd_valid = 1'b1; a_cmd_ir = ir; a_cmd_data = d;
      wait_ready("send", acc);
      if (push) push_exp(d, ir, acc, hold);
      @(negedge clk);
      a_cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((sb.size() != 0 || !a_cmd_ready) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) begin
         checks++; errors++;
         $display("FAIL idle_timeout actual=%0d pending required=0", sb.size());
      end
      @(negedge clk);
   endtask

   function automatic logic [63:0] outs_a();
      return {15'd0, a_cmd_ready, a_resp_valid, a_tck, a_tdi, a_ir_in, a_uir, a_cdr,
              a_sdr, a_udr, a_rti, a_resp_data};
   endfunction

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int acc, acc2, accb, t, prev_id, id, run, toggle_bad, prev_tck;
      logic [63:0] r64;
      logic [DR_W-1:0] d;
      int ids[$], lens[$], exp_ids[$], exp_lens[$];
      localparam logic [63:0] RESET_OUTS = 64'h1 << 48;

      repeat (3) @(negedge clk);
      check("reset_outputs", outs_a(), RESET_OUTS);
      rst = 1'b0;

      // directed loopback with the reference word
      tdo_mode = 0;
      send(2'b01, 38'h15_A5A5_A5A5, 0, 1'b1, acc);
      wait_idle();

      // tdo tied high, all-zero shift data
      tdo_mode = 2;
      send(2'b10, '0, 1, 1'b1, acc);
      wait_idle();

      // cmd_valid held through a transfer, response back-pressured for 20 cycles
      tdo_mode = 0;
      @(negedge clk);
      a_cmd_valid = 1'b1; a_cmd_ir = 2'b11; a_cmd_data = 38'h2A_1234_5678;
      wait_ready("held_a", acc);
      push_exp(38'h2A_1234_5678, 2'b11, acc, 20);
      @(negedge clk);
      a_cmd_ir = 2'b00; a_cmd_data = 38'h01_DEAD_BEEF;
      wait_ready("held_b", acc2);
      push_exp(38'h01_DEAD_BEEF, 2'b00, acc2, 0);
      check("second_accept_cycle", 64'(acc2 - acc), 64'(LAT_A + 20 + 1));
      @(negedge clk);
      a_cmd_valid = 1'b0;
      wait_idle();

      // reset in the middle of DR bit 10
      send(2'b01, 38'h3F_0F0F_0F0F, 0, 1'b0, acc);
      while (cyc < acc + 4 * 12 + 2) @(negedge clk);
      check("in_sdr_before_reset", 64'(a_sdr), 64'd1);
      rst = 1'b1;
      #1;
      check("async_reset_outputs", outs_a(), RESET_OUTS);
      @(negedge clk);
      check("reset_hold_outputs", outs_a(), RESET_OUTS);
      rst = 1'b0;
      send(2'b10, 38'h0A_5555_AAAA, 0, 1'b1, acc);
      wait_idle();

      // randomized traffic
      for (int i = 0; i < 6; i++) begin
         tdo_mode = int'($urandom_range(0, 3));
         r64 = {$urandom, $urandom};
         d = r64[DR_W-1:0];
         send(2'($urandom_range(0, 3)), d, int'($urandom_range(0, 3)), 1'b1, acc);
         wait_idle();
      end

      // TCK_DIV=1 instance: strobe order, durations and tck toggling
      r64 = {$urandom, $urandom};
      d = r64[DR_W-1:0];
      @(negedge clk);
      b_cmd_valid = 1'b1; b_cmd_ir = 2'b10; b_cmd_data = d;
      t = 0;
      while (!b_cmd_ready && t < 100) begin @(negedge clk); t++; end
      accb = cyc;
      prev_id = 0; run = 0; toggle_bad = 0; prev_tck = 0;
      t = 0;
      while (t < 300) begin
         @(negedge clk);
         b_cmd_valid = 1'b0;
         t++;
         if (b_resp_valid) break;
         id = b_uir ? 1 : b_cdr ? 2 : b_sdr ? 3 : b_udr ? 4 : b_rti ? 5 : 0;
         if (prev_id != 0 && int'(b_tck) == prev_tck) toggle_bad++;
         if (id != prev_id) begin
            if (prev_id != 0) begin ids.push_back(prev_id); lens.push_back(run); end
            run = 0;
         end
         run++;
         prev_id = id;
         prev_tck = int'(b_tck);
      end
      if (prev_id != 0) begin ids.push_back(prev_id); lens.push_back(run); end
      exp_ids  = '{1, 2, 3, 4};
      exp_lens = '{2, 2, DR_W * 2, 2};
      if (RTI_P > 0) begin exp_ids.push_back(5); exp_lens.push_back(RTI_P * 2); end
      check("div1_resp_valid", 64'(b_resp_valid), 64'd1);
      check("div1_latency", 64'(cyc - accb), 64'(LAT_B));
      check("div1_resp_data", 64'(b_resp_data), 64'(d));
      check("div1_ir_in", 64'(b_ir_in), 64'(2'b10));
      check("div1_tck_toggle", 64'(toggle_bad), 64'd0);
      check("div1_strobe_runs", 64'(ids.size()), 64'(exp_ids.size()));
      for (int i = 0; i < exp_ids.size() && i < ids.size(); i++) begin
         check("div1_strobe_id", 64'(ids[i]), 64'(exp_ids[i]));
         check("div1_strobe_len", 64'(lens[i]), 64'(exp_lens[i]));
      end
      @(negedge clk);
      check("div1_ready_back", 64'(b_cmd_ready), 64'd1);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
